// File: rtl/sine_sweep_pkg.sv
// Shared types and constants for the sine sweep controller:
// FSM state encoding and the latched sweep configuration record.
package sine_sweep_pkg;

    localparam int POINT_INDEX_WIDTH = 16;
    localparam int CFG_PHASE_W       = 32;
    localparam int CFG_DWELL_W       = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DWELL   = 2'd1,
        ADVANCE = 2'd2,
        DONE    = 2'd3
    } sweep_state_t;

    typedef struct packed {
        logic [CFG_PHASE_W-1:0] start_step;
        logic [CFG_PHASE_W-1:0] stop_step;
        logic [CFG_PHASE_W-1:0] increment;
        logic [CFG_DWELL_W-1:0] dwell;
        logic                   continuous;
    } sweep_cfg_t;

endpackage

// File: rtl/sine_sweep_controller_if.sv
// Control/config/status bundle between the register layer (master)
// and the sweep controller (slave).
interface sine_sweep_if
    import sine_sweep_pkg::*;
#(
    parameter int PHASE_WIDTH = 32,
    parameter int DWELL_WIDTH = 32
) ();

    logic                         start;
    logic                         abort;
    logic [PHASE_WIDTH-1:0]       cfg_start_step;
    logic [PHASE_WIDTH-1:0]       cfg_stop_step;
    logic [PHASE_WIDTH-1:0]       cfg_increment;
    logic [DWELL_WIDTH-1:0]       cfg_dwell_cycles;
    logic                         cfg_continuous;
    logic [PHASE_WIDTH-1:0]       phase_step;
    logic                         step_strobe;
    logic                         busy;
    logic                         done;
    logic [POINT_INDEX_WIDTH-1:0] point_index;

    modport master (
        output start, abort, cfg_start_step, cfg_stop_step, cfg_increment,
               cfg_dwell_cycles, cfg_continuous,
        input  phase_step, step_strobe, busy, done, point_index
    );

    modport slave (
        input  start, abort, cfg_start_step, cfg_stop_step, cfg_increment,
               cfg_dwell_cycles, cfg_continuous,
        output phase_step, step_strobe, busy, done, point_index
    );

endinterface

// File: rtl/sine_sweep_controller.sv
// Linear phase-step sweep sequencer feeding sine_wave_generator_quarter:
// start -> stop by increment, each point held for max(dwell,1)+1 cycles.
module sine_sweep_controller
    import sine_sweep_pkg::*;
#(
    parameter int PHASE_WIDTH = 32,
    parameter int DWELL_WIDTH = 32
) (
    input  logic        clock,
    input  logic        reset,
    sine_sweep_if.slave bus
);

    if (PHASE_WIDTH != CFG_PHASE_W || DWELL_WIDTH != CFG_DWELL_W) begin : g_width_check
        $error("sine_sweep_controller: widths must match sweep_cfg_t field widths");
    end

    sweep_state_t                 r_state;
    sweep_state_t                 w_state_nxt;
    sweep_cfg_t                   r_cfg;
    logic [PHASE_WIDTH-1:0]       r_phase;
    logic [DWELL_WIDTH-1:0]       r_cnt;
    logic [POINT_INDEX_WIDTH-1:0] r_idx;
    logic                         r_strobe;
    logic [PHASE_WIDTH:0]         w_sum;
    logic                         w_terminal;
    logic                         w_go;
    logic                         w_busy;
    logic                         w_done;

    // A dwell of 0 behaves as 1; the counter runs reload..0 inclusive.
    function automatic logic [DWELL_WIDTH-1:0] dwell_reload(input logic [DWELL_WIDTH-1:0] d);
        return (d == '0) ? '0 : d - 1'b1;
    endfunction

    assign w_go       = bus.start & ~bus.abort;
    assign w_sum      = {1'b0, r_phase} + {1'b0, r_cfg.increment};
    assign w_terminal = w_sum[PHASE_WIDTH]
                      | (w_sum[PHASE_WIDTH-1:0] > r_cfg.stop_step)
                      | (r_cfg.increment == '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_go) w_state_nxt = DWELL;
            DWELL:   if (bus.abort) w_state_nxt = IDLE;
                     else if (r_cnt == '0) w_state_nxt = ADVANCE;
            ADVANCE: if (bus.abort) w_state_nxt = IDLE;
                     else if (!w_terminal || r_cfg.continuous) w_state_nxt = DWELL;
                     else w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            DWELL, ADVANCE: w_busy = 1'b1;
            DONE:           w_done = 1'b1;
            default:        ;
        endcase
    end

    // Datapath: phase_step is forced to 0 whenever the sweep is not running.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cfg    <= '0;
            r_phase  <= '0;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_strobe <= 1'b0;
        end else begin
            r_strobe <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_go) begin
                        r_cfg    <= '{start_step: bus.cfg_start_step,
                                      stop_step:  bus.cfg_stop_step,
                                      increment:  bus.cfg_increment,
                                      dwell:      bus.cfg_dwell_cycles,
                                      continuous: bus.cfg_continuous};
                        r_phase  <= bus.cfg_start_step;
                        r_cnt    <= dwell_reload(bus.cfg_dwell_cycles);
                        r_idx    <= '0;
                        r_strobe <= 1'b1;
                    end
                end
                DWELL: begin
                    if (bus.abort) begin
                        r_phase <= '0;
                        r_idx   <= '0;
                    end else if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ADVANCE: begin
                    if (bus.abort) begin
                        r_phase <= '0;
                        r_idx   <= '0;
                    end else if (!w_terminal) begin
                        r_phase  <= w_sum[PHASE_WIDTH-1:0];
                        r_cnt    <= dwell_reload(r_cfg.dwell);
                        r_idx    <= (r_idx == '1) ? r_idx : r_idx + 1'b1;
                        r_strobe <= 1'b1;
                    end else if (r_cfg.continuous) begin
                        r_phase  <= r_cfg.start_step;
                        r_cnt    <= dwell_reload(r_cfg.dwell);
                        r_idx    <= '0;
                        r_strobe <= 1'b1;
                    end else begin
                        r_phase <= '0;
                    end
                end
                DONE: begin
                    r_phase <= '0;
                    r_idx   <= '0;
                end
                default: ;
            endcase
        end
    end

    assign bus.phase_step  = r_phase;
    assign bus.step_strobe = r_strobe;
    assign bus.busy        = w_busy;
    assign bus.done        = w_done;
    assign bus.point_index = r_idx;

endmodule

// File: tb/tb_sine_sweep_controller.sv
// Directed bench for sine_sweep_controller: hand-computed sweep sequences
// checked cycle by cycle with immediate assertions.
module tb_sine_sweep_controller;
    import sine_sweep_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    sine_sweep_if #(.PHASE_WIDTH(32), .DWELL_WIDTH(32)) bus ();

    sine_sweep_controller #(.PHASE_WIDTH(32), .DWELL_WIDTH(32)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input logic [31:0] s, input logic [31:0] p, input logic [31:0] i,
                           input logic [31:0] d, input logic c);
        bus.cfg_start_step   = s;
        bus.cfg_stop_step    = p;
        bus.cfg_increment    = i;
        bus.cfg_dwell_cycles = d;
        bus.cfg_continuous   = c;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic chk_point(input string tag, input int cyc, input logic [31:0] ph,
                             input logic [15:0] idx, input logic strobe);
        chk($sformatf("%s_phase_c%0d", tag, cyc), 64'(bus.phase_step), 64'(ph));
        chk($sformatf("%s_strobe_c%0d", tag, cyc), 64'(bus.step_strobe), 64'(strobe));
        chk($sformatf("%s_idx_c%0d", tag, cyc), 64'(bus.point_index), 64'(idx));
        chk($sformatf("%s_busy_c%0d", tag, cyc), 64'(bus.busy), 64'd1);
        chk($sformatf("%s_done_c%0d", tag, cyc), 64'(bus.done), 64'd0);
    endtask

    // 0,1000,2000,3000 each held 5 cycles; done lands 20 cycles after first strobe.
    task automatic run_basic(input string tag);
        set_cfg(32'd0, 32'd3000, 32'd1000, 32'd4, 1'b0);
        pulse_start();
        bus.cfg_stop_step = 32'd0;
        for (int p = 0; p < 4; p++) begin
            for (int c = 0; c < 5; c++) begin
                chk_point(tag, p * 5 + c, 32'(p * 1000), 16'(p), c == 0);
                tick();
            end
        end
        chk({tag, "_done_pulse"}, 64'(bus.done), 64'd1);
        chk({tag, "_done_phase"}, 64'(bus.phase_step), 64'd0);
        chk({tag, "_done_busy"}, 64'(bus.busy), 64'd0);
        tick();
        chk({tag, "_idle_done"}, 64'(bus.done), 64'd0);
        chk({tag, "_idle_busy"}, 64'(bus.busy), 64'd0);
        chk({tag, "_idle_phase"}, 64'(bus.phase_step), 64'd0);
        chk({tag, "_idle_idx"}, 64'(bus.point_index), 64'd0);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.abort = 1'b0;
        set_cfg(32'd0, 32'd0, 32'd0, 32'd0, 1'b0);

        // Reset state
        #12;
        chk("rst_phase", 64'(bus.phase_step), 64'd0);
        chk("rst_strobe", 64'(bus.step_strobe), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_idx", 64'(bus.point_index), 64'd0);
        rst = 1'b0;
        tick();
        tick();
        chk("idle_busy", 64'(bus.busy), 64'd0);

        run_basic("basic");

        // Overflow terminal: one point only, no wrapped value
        set_cfg(32'hFFFF_F000, 32'hFFFF_FFFF, 32'h0000_1000, 32'd2, 1'b0);
        pulse_start();
        for (int c = 0; c < 3; c++) begin
            chk_point("ovf", c, 32'hFFFF_F000, 16'd0, c == 0);
            tick();
        end
        chk("ovf_done", 64'(bus.done), 64'd1);
        chk("ovf_phase", 64'(bus.phase_step), 64'd0);
        tick();
        chk("ovf_after_busy", 64'(bus.busy), 64'd0);
        chk("ovf_after_strobe", 64'(bus.step_strobe), 64'd0);

        // Continuous: 100,200,300 wrapping, 2 cycles each
        set_cfg(32'd100, 32'd300, 32'd100, 32'd1, 1'b1);
        pulse_start();
        for (int p = 0; p < 8; p++) begin
            for (int c = 0; c < 2; c++) begin
                chk_point("cont", p * 2 + c, 32'(100 * ((p % 3) + 1)), 16'(p % 3), c == 0);
                tick();
            end
        end
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("cont_abort_busy", 64'(bus.busy), 64'd0);
        chk("cont_abort_phase", 64'(bus.phase_step), 64'd0);
        chk("cont_abort_done", 64'(bus.done), 64'd0);

        // Abort mid-dwell at point 2000, with start asserted alongside
        set_cfg(32'd0, 32'd3000, 32'd1000, 32'd4, 1'b0);
        pulse_start();
        for (int c = 0; c < 12; c++) tick();
        chk("abort_pre_phase", 64'(bus.phase_step), 64'd2000);
        chk("abort_pre_idx", 64'(bus.point_index), 64'd2);
        bus.abort = 1'b1;
        bus.start = 1'b1;
        tick();
        chk("abort_phase", 64'(bus.phase_step), 64'd0);
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_done", 64'(bus.done), 64'd0);
        chk("abort_idx", 64'(bus.point_index), 64'd0);
        tick();
        chk("abort_start_idle_busy", 64'(bus.busy), 64'd0);
        chk("abort_start_idle_strobe", 64'(bus.step_strobe), 64'd0);
        bus.abort = 1'b0;
        bus.start = 1'b0;
        tick();
        chk("abort_settle_busy", 64'(bus.busy), 64'd0);
        chk("abort_settle_done", 64'(bus.done), 64'd0);

        // Degenerate: dwell=0, inc=0 -> single point held 2 cycles
        set_cfg(32'd500, 32'd1000, 32'd0, 32'd0, 1'b0);
        pulse_start();
        chk_point("degen", 0, 32'd500, 16'd0, 1'b1);
        bus.start = 1'b1;
        tick();
        chk_point("degen", 1, 32'd500, 16'd0, 1'b0);
        tick();
        chk("degen_done", 64'(bus.done), 64'd1);
        chk("degen_done_phase", 64'(bus.phase_step), 64'd0);
        chk("degen_done_busy", 64'(bus.busy), 64'd0);
        tick();
        chk("degen_idle_busy", 64'(bus.busy), 64'd0);
        chk("degen_idle_strobe", 64'(bus.step_strobe), 64'd0);
        bus.start = 1'b0;
        tick();
        chk("degen_idle2_busy", 64'(bus.busy), 64'd0);
        chk("degen_idle2_done", 64'(bus.done), 64'd0);

        // Async reset between edges mid-sweep
        set_cfg(32'd0, 32'd3000, 32'd1000, 32'd4, 1'b0);
        pulse_start();
        for (int c = 0; c < 7; c++) tick();
        chk("arst_pre_phase", 64'(bus.phase_step), 64'd1000);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_phase", 64'(bus.phase_step), 64'd0);
        chk("arst_busy", 64'(bus.busy), 64'd0);
        chk("arst_strobe", 64'(bus.step_strobe), 64'd0);
        chk("arst_idx", 64'(bus.point_index), 64'd0);
        chk("arst_done", 64'(bus.done), 64'd0);
        #1;
        rst = 1'b0;
        tick();
        chk("arst_idle_busy", 64'(bus.busy), 64'd0);
        run_basic("rerun");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sine_sweep_controller.md
Name: sine_sweep_controller

Overview:
- Sequences the phase_step input of sine_wave_generator_quarter through a programmable linear frequency sweep.
- Steps from a start phase step to a stop phase step by a fixed increment, holding each value for a programmable dwell count.
- Runs in single-shot or continuous (repeat) mode, replacing hand-driven sweep loops.
- Sits between the configuration/register layer and the generator; its phase_step output wires directly to the generator's phase_step input.

Parameters:
- PHASE_WIDTH, 32, width of phase step values; matches the generator phase_step input.
- DWELL_WIDTH, 32, width of the dwell cycle counter.

Ports:
- clock  input  1  system clock; all logic is on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a sweep; honoured only in IDLE.
- abort  input  1  stop the sweep immediately; priority over start.
- cfg_start_step  input  PHASE_WIDTH  first phase step of the sweep.
- cfg_stop_step  input  PHASE_WIDTH  inclusive upper bound on phase step.
- cfg_increment  input  PHASE_WIDTH  phase step added per sweep point.
- cfg_dwell_cycles  input  DWELL_WIDTH  cycles spent at each point; 0 is treated as 1.
- cfg_continuous  input  1  0 = single sweep, 1 = restart from cfg_start_step after the last point.
- phase_step  output  PHASE_WIDTH  phase step to the generator.
- step_strobe  output  1  one-cycle pulse in the first cycle of each new phase_step value.
- busy  output  1  high while a sweep is active (DWELL/ADVANCE).
- done  output  1  one-cycle pulse when a single-shot sweep completes.
- point_index  output  16  index of the current sweep point; saturates at 0xFFFF.

Behaviour:
- Reset (async, active-high): state=IDLE; phase_step=0, step_strobe=0, busy=0, done=0, point_index=0. All registers clear immediately, including mid-sweep.
- States: IDLE, DWELL, ADVANCE, DONE.
- IDLE:
  - phase_step held at 0 (generator parked).
  - On start=1 and abort=0: latch all cfg_* into shadow registers; changes to cfg_* mid-sweep have no effect.
  - Next cycle: phase_step=start_step, step_strobe=1, busy=1, point_index=0, dwell counter loaded with max(dwell,1)-1, state=DWELL.
- DWELL:
  - Counter decrements each cycle.
  - When counter==0, go to ADVANCE.
  - Each point therefore shows exactly max(dwell,1)+1 cycles including the ADVANCE cycle: counter loads with max(dwell,1)-1, then DWELL spends max(dwell,1) cycles and ADVANCE spends 1.
  - Net dwell per point = max(dwell,1)+1 cycles. This is the fixed, documented contract; the bench checks it.
- ADVANCE (one cycle):
  - Compute sum = phase_step + increment in PHASE_WIDTH+1 bits.
  - Terminal if: carry out set, OR sum[PHASE_WIDTH-1:0] > stop_step, OR increment==0.
  - Non-terminal: next cycle phase_step=sum, step_strobe=1, point_index+1 (saturating), reload counter, state=DWELL.
  - Terminal with continuous=1: next cycle phase_step=start_step, step_strobe=1, point_index=0, reload counter, state=DWELL.
  - Terminal with continuous=0: state=DONE.
- DONE (one cycle): done=1, busy=0, phase_step=0; next state IDLE.
- start while busy: ignored.
- start in the DONE cycle: ignored; it is accepted only in IDLE.
- start_step > stop_step: one point at start_step, then terminal.
- abort=1 in any non-IDLE state: next cycle state=IDLE, phase_step=0, busy=0, no done pulse, point_index=0.
- abort and start in the same IDLE cycle: abort wins; nothing starts.
- All arithmetic is unsigned.

Decomposition:
- Shared package sine_sweep_pkg holds:
  - the state enum typedef (IDLE, DWELL, ADVANCE, DONE);
  - constant POINT_INDEX_WIDTH=16;
  - a packed struct typedef for the latched sweep configuration (start, stop, increment, dwell, continuous).
- No sub-module needed. The dwell down-counter stays inline.

Test Plan:
- Basic sweep: start=0, stop=3000, inc=1000, dwell=4, single mode.
  - phase_step = 0, 1000, 2000, 3000, each held 5 cycles.
  - step_strobe pulses 4 times; point_index 0..3.
  - done pulses once, 20 cycles after the first step_strobe.
  - phase_step then returns to 0 and busy drops.
- Overflow terminal: start=0xFFFF_F000, inc=0x1000, stop=0xFFFF_FFFF, dwell=2.
  - Exactly one point at 0xFFFF_F000.
  - Carry detected; done pulses; no wrapped value ever appears on phase_step.
- Continuous mode: start=100, stop=300, inc=100, dwell=1.
  - phase_step cycles 100, 200, 300, 100, ... each held 2 cycles.
  - point_index resets to 0 on each wrap; done never pulses; busy stays 1.
- Abort mid-dwell during a basic sweep at point 2000:
  - Next cycle phase_step=0, busy=0, no done pulse.
  - A start in the same cycle as abort is ignored.
- Degenerate config: dwell=0, inc=0, start=500, stop=1000.
  - Single point at 500 held 2 cycles, then done.
  - A start asserted during busy has no effect on the sequence.
- Async reset asserted mid-sweep between clock edges:
  - Outputs go to 0 immediately.
  - After release, a new start runs the basic sweep correctly from point 0.
